mem_io_responder: RTL and testbench

- Memory-side responder for the edge detector's windowed read/write request interface.
- On each io_start it captures one read request (address, length up to 20 bytes) and one write request (address, length up to 10 bytes, data).
- Reads are serviced first, then writes, over a byte-wide request/grant memory port; read bytes are assembled into read_data.
- io_final pulses when the transaction completes; this is the io_final consumed by the anchor/filter pipeline.

---
 rtl/mem_io_responder_pkg.sv | 13 +
 rtl/mem_io_responder_if.sv | 20 ++
 rtl/mem_io_issue_ctr.sv | 46 ++++
 rtl/mem_io_responder.sv | 126 ++++++++++++
 tb/tb_mem_io_responder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared types and helpers for the edge detector's memory I/O responder.
package edge_detect_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} io_state_t;

  localparam int READ_BLOCK_BYTES  = 20;
  localparam int WRITE_BLOCK_BYTES = 10;

  function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide request/grant memory port; master = responder, slave = memory.
interface mem_io_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_io_issue_ctr.sv
// Issued/received/outstanding counters shared by the read and write phases,
// with the outstanding-read throttle.
module mem_io_issue_ctr #(
  parameter int CNT_W           = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             track,
  input  logic             issue,
  input  logic             retire,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] received,
  output logic             can_issue,
  output logic             pending
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  logic [OUT_W-1:0] outstanding;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else if (clear) begin
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else begin
      if (issue)  issued   <= issued + CNT_W'(1);
      if (retire) received <= received + CNT_W'(1);
      // A grant and a response in the same cycle cancel out.
      if (track && issue && !retire)
        outstanding <= outstanding + OUT_W'(1);
      else if (track && retire && !issue)
        outstanding <= outstanding - OUT_W'(1);
    end
  end

  assign can_issue = outstanding < OUT_MAX;
  assign pending   = outstanding != '0;

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: one read burst then one write burst per io_start.
// Optional MEM_IO_ZERO_FILL_EN clears read_data at io_start.
module mem_io_responder
  import edge_detect_pkg::*;
#(
  parameter int READ_BLOCK      = READ_BLOCK_BYTES,
  parameter int WRITE_BLOCK     = WRITE_BLOCK_BYTES,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         io_start,
  input  logic [31:0]                  read_start_address,
  input  logic [4:0]                   read_length,
  output logic [READ_BLOCK-1:0][7:0]   read_data,
  input  logic [31:0]                  write_start_address,
  input  logic [4:0]                   write_length,
  input  logic [WRITE_BLOCK-1:0][7:0]  write_data,
  output logic                         io_final,
  output logic                         io_busy,
  mem_io_responder_if.master           mem
);
  localparam int CNT_W  = 5;
  localparam int RIDX_W = $clog2(READ_BLOCK);
  localparam int WIDX_W = $clog2(WRITE_BLOCK);

  io_state_t state, next_state;

  logic [31:0]                 raddr, waddr;
  logic [4:0]                  rlen, wlen;
  logic [4:0]                  rlen_in, wlen_in;
  logic [WRITE_BLOCK-1:0][7:0] wdata_q;
  logic [CNT_W-1:0]            issued, received;
  logic                        can_issue, pending;
  logic                        grant, rd_ret, start_ok;

  assign rlen_in  = clamp_len(read_length, 5'(READ_BLOCK));
  assign wlen_in  = clamp_len(write_length, 5'(WRITE_BLOCK));
  assign start_ok = (state == IDLE) && io_start;
  assign grant    = mem.mem_req && mem.mem_gnt;
  assign rd_ret   = (state == READ) && mem.mem_rvalid && pending && (received < rlen);
  assign io_busy  = state != IDLE;

  mem_io_issue_ctr #(
    .CNT_W          (CNT_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ctr (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state != next_state),
    .track    (state == READ),
    .issue    (grant),
    .retire   (rd_ret),
    .issued   (issued),
    .received (received),
    .can_issue(can_issue),
    .pending  (pending)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      raddr   <= read_start_address;
      waddr   <= write_start_address;
      rlen    <= rlen_in;
      wlen    <= wlen_in;
      wdata_q <= write_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      read_data <= '0;
`ifdef MEM_IO_ZERO_FILL_EN
    else if (start_ok)
      read_data <= '0;
`endif
    else if (rd_ret)
      read_data[received[RIDX_W-1:0]] <= mem.mem_rdata;
  end

  // Writes wait in READ until every response is back, so overlapping
  // regions always read the old contents.
  always_comb begin
    next_state    = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    io_final      = 1'b0;
    case (state)
      IDLE: begin
        if (io_start) begin
          if (rlen_in != '0)      next_state = READ;
          else if (wlen_in != '0) next_state = WRITE;
          else                    next_state = DONE;
        end
      end
      READ: begin
        if ((issued < rlen) && can_issue) begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = raddr + 32'(issued);
        end
        if (rd_ret && (received + CNT_W'(1) == rlen))
          next_state = (wlen != '0) ? WRITE : DONE;
      end
      WRITE: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = waddr + 32'(issued);
        mem.mem_wdata = wdata_q[issued[WIDX_W-1:0]];
        if (grant && (issued + CNT_W'(1) == wlen)) next_state = DONE;
      end
      DONE: begin
        io_final   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a memory model and request scoreboard.
module tb_mem_io_responder;
  import edge_detect_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rsp_t;

`ifdef MEM_IO_ZERO_FILL_EN
  localparam logic [7:0] FILL_EXP = 8'h00;
`else
  localparam logic [7:0] FILL_EXP = 8'hFF;
`endif

  logic              clk = 1'b0;
  logic              n_rst;
  logic              io_start;
  logic [31:0]       read_start_address, write_start_address;
  logic [4:0]        read_length, write_length;
  logic [19:0][7:0]  read_data;
  logic [9:0][7:0]   write_data;
  logic              io_final, io_busy;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .io_start           (io_start),
    .read_start_address (read_start_address),
    .read_length        (read_length),
    .read_data          (read_data),
    .write_start_address(write_start_address),
    .write_length       (write_length),
    .write_data         (write_data),
    .io_final           (io_final),
    .io_busy            (io_busy),
    .mem                (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mem_model [logic [31:0]];
  req_t exp_q[$];
  rsp_t pend[$];
  req_t e;
  int   ncyc = 0;
  int   gnt_mode = 0;
  int   rd_lat = 1;
  int   rd_out = 0;
  int   max_out = 0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: grants, requests and responses are all decided on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (!n_rst) begin
      bus.mem_gnt = 1'b0;
      prev_wait   = 1'b0;
    end else begin
      if (prev_wait) begin
        check("hold_req", bus.mem_req, 1);
        check("hold_addr", bus.mem_addr, prev_addr);
      end
      bus.mem_gnt = (gnt_mode == 0) ? 1'b1 : ncyc[0];
      if (bus.mem_req && bus.mem_gnt) begin
        check("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("req_we", bus.mem_we, e.we);
          check("req_addr", bus.mem_addr, e.addr);
          if (e.we) begin
            check("req_wdata", bus.mem_wdata, e.wdata);
            check("wr_after_rd", pend.size(), 0);
            mem_model[bus.mem_addr] = bus.mem_wdata;
          end else begin
            pend.push_back('{ncyc + rd_lat, mem_rd(bus.mem_addr)});
            rd_out++;
            if (rd_out > max_out) max_out = rd_out;
            check("outstanding_max", rd_out <= 4, 1);
          end
        end
      end
      prev_wait = bus.mem_req && !bus.mem_gnt;
      prev_addr = bus.mem_addr;
    end
    if (pend.size() != 0 && pend[0].due <= ncyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = pend[0].data;
      void'(pend.pop_front());
      rd_out--;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'($urandom);
    end
  end

  always @(negedge clk)
    assert (!(io_start && io_busy)) else $error("protocol violation: io_start while io_busy");

  task automatic run_txn(input logic [31:0] ra, input logic [4:0] rl,
                         input logic [31:0] wa, input logic [4:0] wl,
                         input int exp_lat, input string name);
    int rc, wc, n;
    logic [19:0][7:0] exp_rd;
    exp_rd = '0;
    rc = (rl > 5'd20) ? 20 : int'(rl);
    wc = (wl > 5'd10) ? 10 : int'(wl);
    for (int i = 0; i < rc; i++) begin
      exp_rd[i] = mem_rd(ra + 32'(i));
      exp_q.push_back('{1'b0, ra + 32'(i), 8'h00});
    end
    for (int i = 0; i < wc; i++)
      exp_q.push_back('{1'b1, wa + 32'(i), write_data[i]});
    @(negedge clk);
    read_start_address  = ra;
    read_length         = rl;
    write_start_address = wa;
    write_length        = wl;
    io_start            = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    n = 1;
    check({name, ":busy_t1"}, io_busy, 1);
    while (!io_final && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, ":final_seen"}, io_final, 1);
    if (exp_lat >= 0) check({name, ":final_lat"}, n, exp_lat);
    check({name, ":sb_empty"}, exp_q.size(), 0);
    for (int i = 0; i < rc; i++)
      check({name, ":rd_byte"}, read_data[i], exp_rd[i]);
    @(negedge clk);
    check({name, ":final_pulse"}, io_final, 0);
    check({name, ":busy_clear"}, io_busy, 0);
  endtask

  initial begin
    int n;
    n_rst               = 1'b0;
    io_start            = 1'b0;
    read_start_address  = '0;
    read_length         = '0;
    write_start_address = '0;
    write_length        = '0;
    write_data          = '0;
    #1;
    check("rst:io_final", io_final, 0);
    check("rst:io_busy", io_busy, 0);
    check("rst:mem_req", bus.mem_req, 0);
    check("rst:mem_addr", bus.mem_addr, 0);
    check("rst:read_data", read_data, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    run_txn(32'h0, 5'd0, 32'h0, 5'd0, 1, "zero");

    mem_model[32'h100] = 8'hA0;
    mem_model[32'h101] = 8'hA1;
    mem_model[32'h102] = 8'hA2;
    run_txn(32'h100, 5'd3, 32'h0, 5'd0, 5, "rd3");
    check("rd3:packed", read_data[2:0], 24'hA2A1A0);

    for (int i = 0; i < 10; i++) write_data[i] = 8'(i);
    run_txn(32'h0, 5'd0, 32'h200, 5'd10, 11, "wr10");
    check("wr10:mem9", mem_rd(32'h209), 8'h09);

    gnt_mode = 1; rd_lat = 6;
    run_txn(32'h1000, 5'd20, 32'h0, 5'd0, -1, "bp20");

    gnt_mode = 0; rd_lat = 8; max_out = 0;
    run_txn(32'h2000, 5'd31, 32'h0, 5'd0, -1, "rclamp");
    check("rclamp:throttle_hit", max_out, 4);

    rd_lat = 1;
    run_txn(32'hFFFF_FFFE, 5'd4, 32'h0, 5'd0, 6, "wrap");

    for (int i = 0; i < 10; i++) write_data[i] = 8'h50 + 8'(i);
    run_txn(32'h0, 5'd0, 32'h500, 5'd31, 11, "wclamp");

    for (int i = 0; i < 5; i++) begin
      mem_model[32'h600 + 32'(i)] = 8'h30 + 8'(i);
      write_data[i] = 8'hC0 + 8'(i);
    end
    run_txn(32'h600, 5'd5, 32'h600, 5'd5, -1, "ovl");
    check("ovl:new_data", mem_rd(32'h602), 8'hC2);

    // Reset in the middle of a read burst with responses still in flight.
    rd_lat = 6;
    for (int i = 0; i < 20; i++) exp_q.push_back('{1'b0, 32'h3000 + 32'(i), 8'h00});
    @(negedge clk);
    read_start_address = 32'h3000;
    read_length        = 5'd20;
    write_length       = 5'd0;
    io_start           = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid:busy", io_busy, 1);
    check("mid:some_data", read_data != '0, 1);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid:rst_req", bus.mem_req, 0);
    check("mid:rst_busy", io_busy, 0);
    check("mid:rst_final", io_final, 0);
    check("mid:rst_data", read_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b1;
    n = 0;
    while (pend.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid:late_drained", pend.size(), 0);
    repeat (2) @(negedge clk);
    check("mid:late_ignored", read_data, 0);
    check("mid:idle_busy", io_busy, 0);

    rd_lat = 1;
    for (int i = 0; i < 20; i++) mem_model[32'h700 + 32'(i)] = 8'hFF;
    run_txn(32'h700, 5'd20, 32'h0, 5'd0, 22, "ff20");
    run_txn(32'h800, 5'd2, 32'h0, 5'd0, 4, "zf2");
    for (int i = 2; i < 20; i++)
      check("zf2:fill", read_data[i], FILL_EXP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
